// File: rtl/btn_pkg.sv
// Shared definitions for the push-button debounce stage: channel FSM
// encoding and the debounce lengths used in simulation and on the board.
package btn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE_LO = 2'd0,
        ST_WAIT_HI = 2'd1,
        ST_HOLD_HI = 2'd2,
        ST_WAIT_LO = 2'd3
    } btn_state_e;

    localparam int DB_CYCLES_SIM   = 8;
    localparam int DB_CYCLES_BOARD = 2000000;

endpackage

// File: rtl/btn_debounce_ch.sv
// One debounce channel: 2-flop synchronizer, qualification FSM with a
// saturating stability counter, and registered level/press/release outputs.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_BOARD
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int CNT_W = $clog2(DB_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic             sync1_q, sync2_q;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    // Two-flop synchronizer for the asynchronous pin.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

    // Next-state logic; the counter only runs in the WAIT states and is
    // cleared everywhere else, so it can never pass CNT_LAST.
    always_comb begin
        state_d   = state_q;
        cnt_d     = CNT_ZERO;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            ST_IDLE_LO: begin
                level_d = 1'b0;
                if (sync2_q) begin
                    state_d = ST_WAIT_HI;
                end else begin
                    state_d = ST_IDLE_LO;
                end
            end
            ST_WAIT_HI: begin
                if (!sync2_q) begin
                    state_d = ST_IDLE_LO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HOLD_HI;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HOLD_HI: begin
                level_d = 1'b1;
                if (!sync2_q) begin
                    state_d = ST_WAIT_LO;
                end else begin
                    state_d = ST_HOLD_HI;
                end
            end
            ST_WAIT_LO: begin
                if (sync2_q) begin
                    state_d = ST_HOLD_HI;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_IDLE_LO;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE_LO;
                level_d = 1'b0;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE_LO;
            cnt_q     <= CNT_ZERO;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/btn_debounce_step.sv
// Multi-button input conditioning: one independent debounce channel per pin.
module btn_debounce_step
    import btn_pkg::*;
#(
    parameter int NUM_BTN   = 3,
    parameter int DB_CYCLES = DB_CYCLES_BOARD
) (
    input  logic               sys_clk_in,
    input  logic               sys_rst_n,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        btn_debounce_ch #(
            .DB_CYCLES(DB_CYCLES)
        ) u_ch (
            .clk_i    (sys_clk_in),
            .rst_ni   (sys_rst_n),
            .btn_i    (btn_in[g]),
            .level_o  (btn_level[g]),
            .press_o  (btn_press[g]),
            .release_o(btn_release[g])
        );
    end

endmodule

// File: doc/btn_debounce_step.md
Name: btn_debounce_step

Overview:
- Upstream input-conditioning stage for the EGO1 state-machine experiments.
- Takes raw, bouncing, asynchronous push-button inputs and produces clean per-button signals:
  - a synchronized, debounced level for the FSM x-inputs;
  - one-cycle press and release pulses, used as FSM step strobes.
- One instance serves every board button; each button has its own independent debounce channel.

Parameters:
- NUM_BTN, 3, number of button channels (≥1).
- DB_CYCLES, 2000000, stable cycles required to accept a new level (20 ms at 100 MHz). Minimum 2. Benches use 8.
- CNT_W, $clog2(DB_CYCLES)+1, debounce counter width (derived; not overridden).

Ports:
- sys_clk_in  input  1  system clock, 100 MHz, rising edge.
- sys_rst_n  input  1  asynchronous active-low reset.
- btn_in  input  NUM_BTN  raw button pins, active-high, asynchronous to sys_clk_in.
- btn_level  output  NUM_BTN  debounced level per button.
- btn_press  output  NUM_BTN  one-cycle pulse when a channel's debounced level goes 0→1.
- btn_release  output  NUM_BTN  one-cycle pulse when a channel's debounced level goes 1→0.

Behaviour:
- Clock and reset: single clock sys_clk_in; reset sys_rst_n is asynchronous, active-low. All flops clear on assertion; release is taken on the next rising edge.
- Reset values: btn_level=0, btn_press=0, btn_release=0; synchronizers=0; counters=0; all FSMs in IDLE_LO.
- Synchronizer: each btn_in bit passes a 2-flop synchronizer; the result is s. Only s feeds the FSM.
- Per-channel FSM, 2-bit state:
  - IDLE_LO: btn_level=0. If s=1, go to WAIT_HI with cnt←0.
  - WAIT_HI:
    - If s=0, go to IDLE_LO with cnt←0 (bounce rejected, no pulse).
    - Else if cnt==DB_CYCLES-1, go to HOLD_HI; btn_level←1 and btn_press←1 for exactly one cycle.
    - Else cnt←cnt+1.
  - HOLD_HI: btn_level=1. If s=0, go to WAIT_LO with cnt←0.
  - WAIT_LO: mirror of WAIT_HI.
    - If s=1, return to HOLD_HI (no pulse).
    - At cnt==DB_CYCLES-1, go to IDLE_LO; btn_level←0 and btn_release←1 for one cycle.
- Latency: a clean raw edge reaches btn_level and the pulse after 2 (synchronizer) + DB_CYCLES (count) + 1 (registered output) cycles.
  - With DB_CYCLES=8, that is 11 rising edges after the first edge that samples the new value.
- Outputs: all outputs are registered. Pulses are never wider than one cycle. press and release are never asserted together on one channel.
- Bounce: any change of s while counting restarts from the stable state. A glitch shorter than DB_CYCLES cycles never produces a pulse or a level change.
- Held button: a press held indefinitely gives exactly one btn_press pulse. The counter saturates; it does not wrap, and it is idle outside the WAIT states.
- Channel independence: simultaneous presses on several channels pulse in the same cycle when their timing is identical.
- Reset mid-operation: reset during WAIT_HI or HOLD_HI returns the channel to IDLE_LO with btn_level=0 and no release pulse. After reset, a still-held button must be re-qualified for DB_CYCLES and then yields one btn_press.
- Width: cnt is compared against DB_CYCLES-1 truncated to CNT_W. No overflow is possible.

Decomposition:
- Shared package btn_pkg:
  - state encoding localparams ST_IDLE_LO=2'd0, ST_WAIT_HI=2'd1, ST_HOLD_HI=2'd2, ST_WAIT_LO=2'd3;
  - DB_CYCLES_SIM=8;
  - DB_CYCLES_BOARD=2000000.
- Sub-module btn_debounce_ch: one channel, containing the synchronizer, FSM and counter, with parameter DB_CYCLES.
- btn_debounce_step is a generate loop of NUM_BTN btn_debounce_ch instances.

Test Plan (DB_CYCLES=8, NUM_BTN=3):
- Clean press: hold btn_in[0] at 1 for 30 cycles → btn_level[0] rises 11 cycles after the edge; btn_press[0]=1 for exactly 1 cycle; the other channels stay 0.
- Bounce rejection: toggle btn_in[1] 1,0,1,0 with 3-cycle phases, then hold 1 → no pulse during the bounces; a single btn_press[1] 11 cycles after the final rising edge.
- Release: after a held press, drop btn_in[0] to 0 → btn_level[0] falls after 11 cycles; btn_release[0] pulses once; btn_press[0] stays 0.
- Short glitch: a 5-cycle high pulse on btn_in[2] → btn_level[2], btn_press[2] and btn_release[2] all stay 0 throughout.
- Simultaneous: raise btn_in[2:0]=3'b111 on the same cycle → btn_press=3'b111 in one identical cycle; btn_level=3'b111 afterwards.
- Reset mid-op:
  - Assert sys_rst_n=0 for 2 cycles while btn_level[0]=1 with the button held → outputs are 0 asynchronously; no btn_release.
  - After reset release → btn_press[0] pulses 11 cycles later.
